// File: rtl/prng_stream.sv
// ============================================================================
// Module      : prng_stream
// Description : Parametrised Fibonacci-LFSR random-word generator delivering
//               OUT_W-bit words on a valid/ready stream, with runtime seeding.
//               Optional period-wrap detection when PRNG_PERIOD_DET_EN is
//               defined; otherwise period_wrap is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prng_stream #(
  parameter int                 STATE_W      = 16,
  parameter int                 OUT_W        = 8,
  parameter logic [STATE_W-1:0] TAPS         = 16'hD008,
  parameter logic [STATE_W-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               seed_load,
  input  logic [STATE_W-1:0] seed_data,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               period_wrap
);

  localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int               COL_W    = (OUT_W > 1) ? OUT_W - 1 : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_VALID = 1'b1
  } fsm_e;

  fsm_e               fsm_q;
  logic [STATE_W-1:0] lfsr_q;
  logic [STATE_W-1:0] lfsr_d;
  logic [STATE_W-1:0] seed_eff;
  logic [COL_W-1:0]   collect_q;
  logic [OUT_W-1:0]   word_d;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [OUT_W-1:0]   out_data_q;
  logic               out_valid_q;
  logic               fb;
  logic               step;

  assign fb       = ^(lfsr_q & TAPS);
  assign lfsr_d   = {lfsr_q[STATE_W-2:0], fb};
  assign seed_eff = (seed_data == '0) ? DEFAULT_SEED : seed_data;
  assign step     = !seed_load && ena && (fsm_q == S_FILL);

  // Earliest generated bit ends up as the MSB of the completed word.
  if (OUT_W == 1) begin : g_word_single
    assign word_d = fb;
  end else begin : g_word_multi
    assign word_d = {collect_q, fb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_FILL;
      lfsr_q      <= DEFAULT_SEED;
      collect_q   <= '0;
      bit_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (seed_load) begin
      fsm_q       <= S_FILL;
      lfsr_q      <= seed_eff;
      collect_q   <= '0;
      bit_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (fsm_q == S_FILL) begin
      if (ena) begin
        lfsr_q    <= lfsr_d;
        collect_q <= word_d[COL_W-1:0];
        if (bit_cnt_q == LAST_BIT) begin
          out_data_q  <= word_d;
          out_valid_q <= 1'b1;
          bit_cnt_q   <= '0;
          fsm_q       <= S_VALID;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end
    end else begin
      if (out_ready) begin
        out_valid_q <= 1'b0;
        fsm_q       <= S_FILL;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef PRNG_PERIOD_DET_EN
  logic [STATE_W-1:0] ref_q;
  logic               period_wrap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q         <= DEFAULT_SEED;
      period_wrap_q <= 1'b0;
    end else if (seed_load) begin
      ref_q         <= seed_eff;
      period_wrap_q <= 1'b0;
    end else begin
      period_wrap_q <= step && (lfsr_d == ref_q);
    end
  end

  assign period_wrap = period_wrap_q;
`else
  assign period_wrap = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/prng_stream.md
# prng_stream

Parametrised Fibonacci-LFSR random-word generator with a valid/ready output stream, runtime seed loading and optional period-wrap detection. It is the next-generation PRNG core for the design: state width, output width and feedback taps are parameters, and words are delivered only on handshake. It sits between the top-level pin wrapper, which supplies seed and enable, and any downstream consumer of random bytes.

## Interface

- `STATE_W`, default 16: LFSR state width, ≥ 3.
- `OUT_W`, default 8: output word width, 1..STATE_W.
- `TAPS`, default 16'hD008: feedback mask. Bit i set means `state[i]` enters the XOR. The default is x^16+x^15+x^13+x^4+1, which is maximal length.
- `DEFAULT_SEED`, default 16'hACE1: reset and zero-substitute seed. Must be non-zero.

- `clk`  in  1  — clock; all logic on the rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `ena`  in  1  — step enable; when low, LFSR and fill counter freeze.
- `seed_load`  in  1  — single-cycle strobe; loads `seed_data`.
- `seed_data`  in  STATE_W  — seed value.
- `out_data`  out  OUT_W  — random word; stable while `out_valid` is high.
- `out_valid`  out  1  — word available.
- `out_ready`  in  1  — consumer accepts the word.
- `period_wrap`  out  1  — one-cycle pulse when the state returns to the last loaded seed. Only present in behaviour with the macro below.

## Operation

- **Step:**
  - `fb` = XOR-reduce(`state & TAPS`).
  - `state` ← {`state[STATE_W-2:0]`, `fb`}.
- **Word assembly:** each step shifts `fb` into a collect register. The first bit generated becomes the MSB of `out_data`.
- **FSM states:** FILL, VALID.
  - **FILL:** each cycle with `ena`=1, one step and `bit_cnt`++. On the step where `bit_cnt`==OUT_W-1:
    - `out_data` ← {collect[OUT_W-2:0], `fb`}
    - `out_valid` ← 1
    - `bit_cnt` ← 0
    - go to VALID.
  - **VALID:** no stepping. `out_valid`&&`out_ready` completes the transfer: `out_valid` ← 0, go to FILL. A handshake completes regardless of `ena`.
- **Seed load:** `seed_load`=1 has top priority in any state.
  - `state` ← `seed_data`, or `DEFAULT_SEED` if `seed_data`==0.
  - `bit_cnt` ← 0 and collect register cleared.
  - `out_valid` ← 0, go to FILL.
  - The load ignores `ena`.
  - No step occurs in the load cycle.
- **Reset values:**
  - `state`=`DEFAULT_SEED`, FSM=FILL, `bit_cnt`=0.
  - `out_data`=0, `out_valid`=0, `period_wrap`=0.
- The state never reaches zero, because only non-zero values are loaded.

## Timing

- From reset release, or from a seed load, with `ena` held high, `out_valid` rises on the OUT_W-th rising edge.
- Sustained throughput: one word per OUT_W+1 cycles with `out_ready` held high (OUT_W fill cycles plus 1 VALID cycle).
- `ena` low during FILL stalls assembly. Already-collected bits are kept, and assembly resumes when `ena` returns high.
- Seed load in the same cycle as a handshake: the load wins. The word counts as consumed, and `out_valid` is 0 the next cycle.
- `rst_n` asserted mid-fill or mid-VALID: immediate return to the reset values. Any partial word is discarded.

## Configuration

- **Macro `PRNG_PERIOD_DET_EN` defined:**
  - A reference register holds the seed last loaded, or `DEFAULT_SEED` after reset.
  - After any step whose new state equals the reference, `period_wrap` is high for exactly the next cycle.
  - For a maximal TAPS this happens every 2^STATE_W−1 steps.
- **Macro not defined:**
  - `period_wrap` is tied to 0.
  - No reference register is synthesised.

## Test plan

The bench uses STATE_W=4, OUT_W=4, TAPS=4'b1100 unless stated otherwise.

- **Seed and first words:** load seed 4'b0001, `ena`=1, `out_ready`=0 → `out_valid` rises after 4 cycles with `out_data`=4'b0011. It holds for 10 cycles unchanged. Pulse `out_ready` → the next word is 4'b0101.
- **Zero seed:** load `seed_data`=0 with DEFAULT_SEED=4'b0001 → same word sequence as the previous test (0011, then 0101).
- **Enable stall:** drop `ena` for 5 cycles after 2 fill steps → `out_data` is still 4'b0011, and `out_valid` rises after 4 cycles of `ena`=1 in total.
- **Load collision:** assert `seed_load` in the same cycle as `out_valid`&&`out_ready` → `out_valid` is 0 next cycle, and the sequence restarts from the new seed.
- **Async reset:** assert `rst_n` low mid-fill, asynchronously between edges → `out_valid`=0 and `out_data`=0 at once, and the state returns to DEFAULT_SEED.
- **Period wrap (with `PRNG_PERIOD_DET_EN`):** load seed 4'b0001 with `ena`=1 and `out_ready`=1 → `period_wrap` pulses exactly once per 15 steps, for one cycle. Without the macro, `period_wrap` stays 0 throughout.
